result_collector: RTL and testbench

Output stage placed directly downstream of the last weight_comp_cell in a systolic chain. It captures each valid accumulated result, adds a bias, and requantizes it with a rounding shift, zero-point offset and unsigned saturation. Results are buffered in a small FIFO and presented on a ready/valid stream with a per-frame last marker. The cell chain cannot be stalled, so FIFO overflow drops data and raises a sticky flag.

---
 rtl/result_collector.sv | 199 +++++++++++++++++++
 tb/tb_result_collector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//
// Output stage behind the last weight_comp_cell of a systolic chain. Each
// valid accumulated result is captured. A bias and a round-half-up constant
// are added to it, and it is requantized with an arithmetic shift, a
// zero-point offset and unsigned saturation. The result is then buffered in a
// show-ahead FIFO and presented on a ready/valid stream with a per-frame last
// marker. The upstream chain cannot be stalled, so a result that arrives while
// the FIFO is full is dropped and a sticky overflow flag is raised.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   input_result  {valid, signed result[RESULT_WIDTH-1:0]} from the last cell
//   input_enable  enable from the last cell; capture needs enable and valid
//   out_data      requantized value at the FIFO head (0 when empty)
//   out_last      head entry closes a frame (0 when empty)
//   out_valid     FIFO not empty
//   out_ready     consumer accepts the head entry
//   frame_done    one-cycle pulse, aligned with the write of a frame's last result
//   overflow      sticky drop indicator, cleared only by reset
// -----------------------------------------------------------------------------
module result_collector #(
  parameter int                             RESULT_WIDTH = 32,
  parameter int                             OUTPUT_WIDTH = 8,
  parameter int                             SHIFT        = 8,
  parameter logic signed [RESULT_WIDTH-1:0] BIAS         = '0,
  parameter int                             ZERO_POINT   = 0,
  parameter int                             FIFO_DEPTH   = 4,
  parameter int                             RESULT_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RESULT_WIDTH:0]   input_result,
  input  logic                    input_enable,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic                    overflow
);

  // Stage-1 sum width: two guard bits, so result + BIAS + round cannot wrap.
  localparam int SW   = RESULT_WIDTH + 2;
  // Stage-2 width: wide enough for the sum of the shifted value and a 32-bit zero point.
  localparam int QW   = SW + 34;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int CNTW = (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1;
  localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [SW-1:0] BIAS_EXT = {{2{BIAS[RESULT_WIDTH-1]}}, BIAS};
  // Round half up: add half an LSB of the shifted result before shifting.
  localparam logic signed [SW-1:0] ROUND    = (SHIFT > 0) ? (SW'(1) << RSH) : '0;
  localparam logic signed [QW-1:0] SAT_MAX  =
    {{(QW - OUTPUT_WIDTH){1'b0}}, {OUTPUT_WIDTH{1'b1}}};

  typedef struct packed {
    logic                    last;
    logic [OUTPUT_WIDTH-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Capture and stage 1
  // ---------------------------------------------------------------------------
  logic                 capture;
  logic                 cnt_last;
  logic signed [SW-1:0] result_ext;
  logic signed [SW-1:0] sum_d;

  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic signed [SW-1:0] s1_sum_q;

  assign capture    = input_enable & input_result[RESULT_WIDTH];
  assign cnt_last   = (cnt_q == CNTW'(RESULT_COUNT - 1));
  assign result_ext = {{2{input_result[RESULT_WIDTH-1]}}, input_result[RESULT_WIDTH-1:0]};
  assign sum_d      = result_ext + BIAS_EXT + ROUND;

  // ---------------------------------------------------------------------------
  // Stage 2: shift, zero point, saturate
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0]    shifted;
  logic signed [QW-1:0]    q_wide;
  logic [OUTPUT_WIDTH-1:0] sat_data;

  assign shifted = s1_sum_q >>> SHIFT;
  assign q_wide  = QW'(shifted) + QW'(ZERO_POINT);

  always_comb begin
    // NOTE: assign every always_comb output a default before any branch.
    // A path that leaves a variable unassigned infers a latch.
    sat_data = q_wide[OUTPUT_WIDTH-1:0];
    if (q_wide[QW-1]) begin
      sat_data = '0;
    end else if (q_wide > SAT_MAX) begin
      sat_data = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  logic          empty, full, pop, push, drop;
  entry_t        head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  // A pop in the same cycle frees the slot that a write into a full FIFO needs.
  assign push  = s1_valid_q & (~full | pop);
  assign drop  = s1_valid_q & full & ~pop;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d        = cnt_q;
    s1_valid_d   = capture;
    s1_last_d    = capture & cnt_last;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_done_d = s1_valid_q & s1_last_q;
    overflow_d   = overflow_q | drop;

    // Dropped results still advance the frame counter; only capture matters.
    if (capture) begin
      cnt_d = cnt_last ? '0 : cnt_q + CNTW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: use non-blocking assignments for all clocked state. Every register
  // then samples pre-edge values, with no dependence on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: the data paths (stage-1 sum and FIFO storage) have no reset. Their
  // contents are only observed behind a valid bit or a non-zero count, and
  // those are reset. Leaving the data paths unreset keeps them plain flops or RAM.
  always_ff @(posedge clk) begin
    if (capture) begin
      s1_sum_q <= sum_d;
    end
    if (push) begin
      mem_q[wr_ptr_q] <= '{last: s1_last_q, data: sat_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid  = ~empty;
  assign out_data   = empty ? '0 : head.data;
  assign out_last   = ~empty & head.last;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// -----------------------------------------------------------------------------
// tb_result_collector
//
// Self-checking bench for result_collector. A queue-level reference model
// drives the expected values: a one-deep "pending" slot for the capture stage,
// a bounded queue for the FIFO, and a frame counter. Two extra instances cover
// the non-default ZERO_POINT and BIAS settings.
// -----------------------------------------------------------------------------
module tb_result_collector;

  localparam int RW    = 32;
  localparam int OW    = 8;
  localparam int SH    = 8;
  localparam int DEPTH = 4;
  localparam int RCNT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW:0]   in_result;
  logic          in_enable;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last, out_valid, frame_done, overflow;

  logic [RW:0]   aux_result;
  logic          aux_enable, aux_ready;
  logic [OW-1:0] zp_data, b_data;
  logic          zp_last, zp_valid, zp_fd, zp_ovf;
  logic          b_last, b_valid, b_fd, b_ovf;

  always #5 clk = ~clk;

  result_collector dut (
    .clk(clk), .rst_n(rst_n), .input_result(in_result), .input_enable(in_enable),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .overflow(overflow)
  );

  result_collector #(.ZERO_POINT(128)) dut_zp (
    .clk(clk), .rst_n(rst_n), .input_result(aux_result), .input_enable(aux_enable),
    .out_data(zp_data), .out_last(zp_last), .out_valid(zp_valid),
    .out_ready(aux_ready), .frame_done(zp_fd), .overflow(zp_ovf)
  );

  result_collector #(.BIAS(-256)) dut_b (
    .clk(clk), .rst_n(rst_n), .input_result(aux_result), .input_enable(aux_enable),
    .out_data(b_data), .out_last(b_last), .out_valid(b_valid),
    .out_ready(aux_ready), .frame_done(b_fd), .overflow(b_ovf)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit last;
    int data;
  } exp_t;

  exp_t mdl_q[$];
  bit   pend_v, pend_l;
  int   pend_d;
  int   frame_n;
  bit   mdl_ovf, mdl_fd;

  int checks = 0;
  int errors = 0;

  // Requantization straight from the arithmetic definition.
  function automatic int requant(longint r, longint bias, longint zp);
    longint s, q;
    s = r + bias + ((SH > 0) ? (longint'(1) <<< (SH - 1)) : longint'(0));
    q = (s >>> SH) + zp;
    if (q < 0) return 0;
    if (q > (longint'(1) <<< OW) - 1) return (1 << OW) - 1;
    return int'(q);
  endfunction

  function automatic logic [RW:0] vr(input int v);
    return {1'b1, v[RW-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    pend_v  = 1'b0;
    pend_l  = 1'b0;
    pend_d  = 0;
    frame_n = 0;
    mdl_ovf = 1'b0;
    mdl_fd  = 1'b0;
  endtask

  task automatic check_outputs();
    bit v;
    v = (mdl_q.size() > 0);
    check("out_valid", 64'(out_valid), 64'(v));
    check("out_data", 64'(out_data), v ? 64'(mdl_q[0].data) : 64'd0);
    check("out_last", 64'(out_last), v ? 64'(mdl_q[0].last) : 64'd0);
    check("overflow", 64'(overflow), 64'(mdl_ovf));
    check("frame_done", 64'(frame_done), 64'(mdl_fd));
  endtask

  // One clock cycle: check at the negedge, drive inputs, advance the model
  // across the rising edge, and return at the next negedge.
  task automatic step(input logic [RW:0] res, input bit en, input bit rdy);
    bit popped;
    check_outputs();
    in_result = res;
    in_enable = en;
    out_ready = rdy;
    @(posedge clk);
    popped = (mdl_q.size() > 0) && rdy;
    if (popped) void'(mdl_q.pop_front());
    mdl_fd = pend_v && pend_l;
    if (pend_v) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back('{last: pend_l, data: pend_d});
      else mdl_ovf = 1'b1;
    end
    pend_v = en && res[RW];
    if (pend_v) begin
      frame_n++;
      pend_l = (frame_n == RCNT);
      if (pend_l) frame_n = 0;
      pend_d = requant(longint'($signed(res[RW-1:0])), 0, 0);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step('0, 1'b0, rdy);
  endtask

  // Called at a negedge; reset takes effect immediately and is checked 1 ns later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_last", 64'(out_last), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst frame_done", 64'(frame_done), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic aux_send(input int v);
    aux_result = vr(v);
    aux_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aux_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("zp valid", 64'(zp_valid), 64'd1);
    check("zp data", 64'(zp_data), 64'(requant(longint'(v), 0, 128)));
    check("bias valid", 64'(b_valid), 64'd1);
    check("bias data", 64'(b_data), 64'(requant(longint'(v), -256, 0)));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_result  = '0;
    in_enable  = 1'b0;
    out_ready  = 1'b0;
    aux_result = '0;
    aux_enable = 1'b0;
    aux_ready  = 1'b1;
    model_reset();
    #1;
    check("init out_valid", 64'(out_valid), 64'd0);
    check("init overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rounding and saturation, back-to-back, one full frame plus one.
    step(vr(896), 1'b1, 1'b1);
    step(vr(384), 1'b1, 1'b1);
    step(vr(1000), 1'b1, 1'b1);
    step(vr(70000), 1'b1, 1'b1);
    step(vr(-300), 1'b1, 1'b1);
    idle(4, 1'b1);

    // Enable gating: neither half of the capture condition alone writes.
    step(vr(512), 1'b0, 1'b1);
    step({1'b0, 32'd512}, 1'b1, 1'b1);
    step(vr(768), 1'b0, 1'b1);
    idle(2, 1'b1);

    // Zero point and bias instances.
    do_reset();
    aux_send(-300);
    aux_send(512);

    // Backpressure and overflow.
    do_reset();
    for (int i = 1; i <= 6; i++) step(vr(256 * i), 1'b1, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 1; i <= 4; i++) step(vr(256 * i), 1'b1, 1'b0);
    idle(1, 1'b0);
    for (int i = 5; i <= 12; i++) step(vr(256 * i), 1'b1, 1'b1);
    idle(6, 1'b1);

    // Reset with three entries queued and one in flight.
    do_reset();
    for (int i = 1; i <= 4; i++) step(vr(256 * i), 1'b1, 1'b0);
    do_reset();
    idle(2, 1'b1);
    for (int i = 1; i <= 4; i++) step(vr(300 * i), 1'b1, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int  val;
      bit  en, vb, rdy;
      en  = ($urandom_range(0, 3) != 0);
      vb  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) val = int'($urandom());
      else val = int'($urandom_range(0, 72000)) - 2000;
      step({vb, val[RW-1:0]}, en, rdy);
    end
    idle(8, 1'b1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
